alu_control_mdu: RTL and testbench

- Parametrised successor to the EX-stage ALU control decoder. Decodes aluOp/funcCode into a 4-bit ALU operation code and executes single-cycle ALU ops combinationally.
- Adds an iterative multiply/divide unit with HI/LO registers for mult, multu, div, divu, mfhi and mflo.
- Asserts a busy stall toward the hazard unit while an operation is in flight.
- Sits in EX, between the ID/EX and EX/MEM pipeline registers.

---
 rtl/alu_pkg.sv | 56 +++++
 rtl/alu_control_mdu_mdu_seq.sv | 106 ++++++++++
 rtl/alu_control_mdu.sv | 90 +++++++++
 tb/tb_alu_control_mdu.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU control decoder and the iterative MDU.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 32;

   typedef enum logic [3:0] {
      CTRL_AND     = 4'b0000,
      CTRL_OR      = 4'b0001,
      CTRL_ADD     = 4'b0010,
      CTRL_SUB     = 4'b0110,
      CTRL_SLT     = 4'b0111,
      CTRL_MULT    = 4'b1000,
      CTRL_MULTU   = 4'b1001,
      CTRL_DIV     = 4'b1010,
      CTRL_DIVU    = 4'b1011,
      CTRL_NOR     = 4'b1100,
      CTRL_MFHI    = 4'b1101,
      CTRL_MFLO    = 4'b1110,
      CTRL_INVALID = 4'b1111
   } alu_ctrl_e;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_RIMM  = 2'b11;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;

   typedef enum logic [1:0] {
      MDU_IDLE,
      MDU_ITER,
      MDU_FIX
   } mdu_state_e;

   // Order matches the low two bits of the MULT..DIVU control codes.
   typedef enum logic [1:0] {
      K_MULT,
      K_MULTU,
      K_DIV,
      K_DIVU
   } mdu_kind_e;

endpackage

// File: rtl/alu_control_mdu_mdu_seq.sv
// Iterative radix-2 multiply / restoring divide with sign fix-up and HI/LO registers.
module mdu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  mdu_kind_e        kind,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   mdu_state_e         state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   acc, qr, mb;
   logic               neg_a, neg_b, is_div, dz;

   logic               signed_op, sa, sb;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     add_sum, shifted, sub_diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;

   assign signed_op = (kind == K_MULT) || (kind == K_DIV);
   assign sa        = signed_op & opa[WIDTH-1];
   assign sb        = signed_op & opb[WIDTH-1];
   assign mag_a     = sa ? -opa : opa;
   assign mag_b     = sb ? -opb : opb;
   assign busy      = (state != MDU_IDLE);

   // acc/qr are shared: {acc,qr} is the product shift pair for multiply,
   // and remainder/quotient (dividend shifting out of qr) for divide.
   assign add_sum  = {1'b0, acc} + (qr[0] ? {1'b0, mb} : '0);
   assign shifted  = {acc, qr[WIDTH-1]};
   assign sub_diff = shifted - {1'b0, mb};

   assign prod = (neg_a ^ neg_b) ? -{acc, qr} : {acc, qr};
   assign quo  = dz ? '1 : ((neg_a ^ neg_b) ? -qr : qr);
   assign rem  = neg_a ? -acc : acc;

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= MDU_IDLE;
         cnt    <= '0;
         acc    <= '0;
         qr     <= '0;
         mb     <= '0;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         is_div <= 1'b0;
         dz     <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            MDU_IDLE: begin
               if (start) begin
                  state  <= MDU_ITER;
                  cnt    <= CNT_W'(WIDTH - 1);
                  acc    <= '0;
                  qr     <= mag_a;
                  mb     <= mag_b;
                  neg_a  <= sa;
                  neg_b  <= sb;
                  is_div <= (kind == K_DIV) || (kind == K_DIVU);
                  dz     <= (opb == '0);
               end
            end
            MDU_ITER: begin
               if (is_div) begin
                  acc <= sub_diff[WIDTH] ? shifted[WIDTH-1:0] : sub_diff[WIDTH-1:0];
                  qr  <= {qr[WIDTH-2:0], ~sub_diff[WIDTH]};
               end else begin
                  acc <= add_sum[WIDTH:1];
                  qr  <= {add_sum[0], qr[WIDTH-1:1]};
               end
               cnt <= cnt - CNT_W'(1);
               if (cnt == '0) state <= MDU_FIX;
            end
            MDU_FIX: begin
               if (is_div) begin
                  hi <= rem;
                  lo <= quo;
               end else begin
                  hi <= prod[2*WIDTH-1:WIDTH];
                  lo <= prod[WIDTH-1:0];
               end
               done  <= 1'b1;
               state <= MDU_IDLE;
            end
            default: state <= MDU_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/alu_control_mdu.sv
// EX-stage ALU control decoder and single-cycle ALU, fronting the iterative MDU.
module alu_control_mdu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       aluOp,
   input  logic [5:0]       funcCode,
   input  logic             start,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic [3:0]       aluCtrl,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   alu_ctrl_e dec;
   logic      mdu_go;

   always_comb begin
      dec = CTRL_INVALID;
      case (aluOp)
         ALUOP_ADD: dec = CTRL_ADD;
         ALUOP_SUB: dec = CTRL_SUB;
         ALUOP_RIMM: begin
            if (funcCode == FN_SUB)      dec = CTRL_SUB;
            else if (funcCode == FN_SLT) dec = CTRL_SLT;
         end
         ALUOP_RTYPE: begin
            case (funcCode)
               FN_ADD, FN_ADDU: dec = CTRL_ADD;
               FN_SUB, FN_SUBU: dec = CTRL_SUB;
               FN_AND:          dec = CTRL_AND;
               FN_OR:           dec = CTRL_OR;
               FN_NOR:          dec = CTRL_NOR;
               FN_SLT:          dec = CTRL_SLT;
               FN_MULT:         dec = CTRL_MULT;
               FN_MULTU:        dec = CTRL_MULTU;
               FN_DIV:          dec = CTRL_DIV;
               FN_DIVU:         dec = CTRL_DIVU;
               FN_MFHI:         dec = CTRL_MFHI;
               FN_MFLO:         dec = CTRL_MFLO;
               default:         dec = CTRL_INVALID;
            endcase
         end
         default: dec = CTRL_INVALID;
      endcase
      if (reset) dec = CTRL_INVALID;
   end

   assign aluCtrl = dec;
   assign mdu_go  = start && (dec inside {CTRL_MULT, CTRL_MULTU, CTRL_DIV, CTRL_DIVU});

   always_comb begin
      result = '0;
      case (dec)
         CTRL_AND:  result = opA & opB;
         CTRL_OR:   result = opA | opB;
         CTRL_NOR:  result = ~(opA | opB);
         CTRL_ADD:  result = opA + opB;
         CTRL_SUB:  result = opA - opB;
         CTRL_SLT:  result = WIDTH'($signed(opA) < $signed(opB));
         CTRL_MFHI: result = busy ? '0 : hi;
         CTRL_MFLO: result = busy ? '0 : lo;
         default:   result = '0;
      endcase
   end

   assign zero = (result == '0);

   mdu_seq #(.WIDTH(WIDTH)) u_mdu (
      .clock (clock),
      .reset (reset),
      .start (mdu_go),
      .kind  (mdu_kind_e'(dec[1:0])),
      .opa   (opA),
      .opb   (opB),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

endmodule

// File: tb/tb_alu_control_mdu.sv
// Randomized bench for alu_control_mdu against a behavioural ALU/MDU model.
module tb_alu_control_mdu;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  aluOp;
   logic [5:0]  funcCode;
   logic        start;
   logic [31:0] opA, opB;
   logic [3:0]  aluCtrl;
   logic [31:0] result;
   logic        zero, busy, done;
   logic [31:0] hi, lo;

   logic [1:0]  aluOp8;
   logic [5:0]  funcCode8;
   logic        start8;
   logic [7:0]  opA8, opB8;
   logic [3:0]  aluCtrl8;
   logic [7:0]  result8, hi8, lo8;
   logic        zero8, busy8, done8;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   always #5 clock = ~clock;

   alu_control_mdu dut (
      .clock(clock), .reset(reset), .aluOp(aluOp), .funcCode(funcCode), .start(start),
      .opA(opA), .opB(opB), .aluCtrl(aluCtrl), .result(result), .zero(zero),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   alu_control_mdu #(.WIDTH(8)) dut8 (
      .clock(clock), .reset(reset), .aluOp(aluOp8), .funcCode(funcCode8), .start(start8),
      .opA(opA8), .opB(opB8), .aluCtrl(aluCtrl8), .result(result8), .zero(zero8),
      .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] m_ctrl(input logic [1:0] op, input logic [5:0] f);
      case (op)
         2'b00: return 4'b0010;
         2'b01: return 4'b0110;
         2'b11: return (f == 6'b100010) ? 4'b0110 : (f == 6'b101010) ? 4'b0111 : 4'b1111;
         default: case (f)
            6'b100000, 6'b100001: return 4'b0010;
            6'b100010, 6'b100011: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b100111: return 4'b1100;
            6'b101010: return 4'b0111;
            6'b011000: return 4'b1000;
            6'b011001: return 4'b1001;
            6'b011010: return 4'b1010;
            6'b011011: return 4'b1011;
            6'b010000: return 4'b1101;
            6'b010010: return 4'b1110;
            default:   return 4'b1111;
         endcase
      endcase
   endfunction

   function automatic logic [31:0] m_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b1100: return ~(a | b);
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1101: return m_hi;
         4'b1110: return m_lo;
         default: return 32'd0;
      endcase
   endfunction

   // Returns {hi, lo} for one MDU instruction.
   function automatic logic [63:0] m_mdu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      logic [31:0] q, r;
      case (f)
         6'b011000: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return sp;
         end
         6'b011001: return {32'd0, a} * {32'd0, b};
         6'b011010: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
         end
         6'b011011: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [5:0] pick_funct();
      case ($urandom % 14)
         0: return 6'b100000;  1: return 6'b100001;  2: return 6'b100010;
         3: return 6'b100011;  4: return 6'b100100;  5: return 6'b100101;
         6: return 6'b100111;  7: return 6'b101010;  8: return 6'b010000;
         9: return 6'b010010; 10: return 6'b011000; 11: return 6'b011010;
         default: return 6'($urandom);
      endcase
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom % 6)
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   // mode 0: plain; 1: MFLO held from busy cycle 5; 2: second MDU start during busy
   task automatic run_mdu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input int mode);
      logic [63:0] e;
      int nb;
      e = m_mdu(f, a, b);
      @(negedge clock);
      aluOp = 2'b10; funcCode = f; opA = a; opB = b; start = 1'b1;
      @(negedge clock);
      start = 1'b0; funcCode = 6'b100000;
      nb = 0;
      while (busy && nb < 100) begin
         nb++;
         if (mode == 1 && nb == 5) begin funcCode = 6'b010010; start = 1'b1; end
         if (mode == 2 && nb == 5) begin funcCode = 6'b011000; opA = $urandom; opB = $urandom; start = 1'b1; end
         if (mode == 2 && nb == 6) begin funcCode = 6'b100000; start = 1'b0; end
         if (mode == 1 && nb >= 5) begin
            #1 chk("mflo_stalled", {32'd0, result}, 64'd0);
         end
         @(negedge clock);
      end
      chk("busy_cycles", 64'(nb), 64'd33);
      chk("done_pulse", {63'd0, done}, 64'd1);
      chk("hi", {32'd0, hi}, {32'd0, e[63:32]});
      chk("lo", {32'd0, lo}, {32'd0, e[31:0]});
      if (mode == 1) begin
         #1 chk("mflo_held", {32'd0, result}, {32'd0, e[31:0]});
      end else begin
         funcCode = 6'b010000;
         #1 chk("mfhi_done_cycle", {32'd0, result}, {32'd0, e[63:32]});
      end
      m_hi = e[63:32];
      m_lo = e[31:0];
      start = 1'b0; funcCode = 6'b100000;
      @(negedge clock);
      chk("done_single", {63'd0, done}, 64'd0);
      chk("idle_after", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      logic [3:0]  c;
      logic [31:0] r;
      logic [5:0]  f;
      logic [5:0]  dfn [7];
      logic [3:0]  dct [7];
      logic [31:0] drs [7];
      int nd, nb;

      dfn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b111111};
      dct = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b1111};
      drs = '{32'd16, 32'hFFFF_FFFE, 32'd1, 32'd15, 32'hFFFF_FFF0, 32'd1, 32'd0};

      reset = 1'b1; aluOp = 2'b10; funcCode = 6'b100000; start = 1'b0; opA = 32'd7; opB = 32'd9;
      aluOp8 = 2'b10; funcCode8 = 6'b100000; start8 = 1'b0; opA8 = '0; opB8 = '0;
      repeat (3) @(negedge clock);
      chk("rst_ctrl", {60'd0, aluCtrl}, 64'hF);
      chk("rst_result", {32'd0, result}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         aluOp = 2'b10; funcCode = dfn[i]; opA = 32'd7; opB = 32'd9;
         #1;
         chk("dir_ctrl", {60'd0, aluCtrl}, {60'd0, dct[i]});
         chk("dir_result", {32'd0, result}, {32'd0, drs[i]});
      end

      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         chk("no_mdu_start", {63'd0, busy}, 64'd0);
         aluOp = 2'($urandom);
         f = pick_funct();
         funcCode = f;
         opA = rnd_op();
         opB = ($urandom % 4 == 0) ? opA : rnd_op();
         c = m_ctrl(aluOp, f);
         start = (c inside {4'b1000, 4'b1001, 4'b1010, 4'b1011}) ? 1'b0 : 1'($urandom);
         r = m_res(c, opA, opB);
         #1;
         chk("rnd_ctrl", {60'd0, aluCtrl}, {60'd0, c});
         chk("rnd_result", {32'd0, result}, {32'd0, r});
         chk("rnd_zero", {63'd0, zero}, {63'd0, (r == 32'd0)});
      end
      @(negedge clock);
      start = 1'b0;

      run_mdu(6'b011000, 32'hFFFF_FFFD, 32'd5, 0);
      run_mdu(6'b011001, 32'hFFFF_FFFF, 32'd2, 0);
      run_mdu(6'b011010, 32'hFFFF_FFF9, 32'd2, 0);
      run_mdu(6'b011011, 32'd7, 32'd0, 0);
      run_mdu(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_mdu(6'b011010, 32'hFFFF_FF85, 32'd0, 0);
      run_mdu(6'b011010, 32'd1000, 32'hFFFF_FFF9, 1);
      run_mdu(6'b011001, 32'h1234_5678, 32'h9ABC_DEF0, 2);
      for (int i = 0; i < 16; i++)
         run_mdu(6'b011000 | 6'($urandom % 4), rnd_op(), rnd_op(), 0);

      // mid-operation reset
      @(negedge clock);
      aluOp = 2'b10; funcCode = 6'b011000; opA = 32'hDEAD_BEEF; opB = 32'h0000_1234; start = 1'b1;
      @(negedge clock);
      start = 1'b0; funcCode = 6'b100000;
      repeat (9) @(negedge clock);
      reset = 1'b1;
      #1;
      chk("midrst_ctrl", {60'd0, aluCtrl}, 64'hF);
      chk("midrst_result", {32'd0, result}, 64'd0);
      @(negedge clock);
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_hilo", {hi, lo}, 64'd0);
      reset = 1'b0;
      m_hi = '0; m_lo = '0;
      nd = 0;
      repeat (40) begin
         @(negedge clock);
         if (done || busy) nd++;
      end
      chk("midrst_no_done", 64'(nd), 64'd0);
      run_mdu(6'b011000, 32'd6, 32'd7, 0);

      // 8-bit instance
      @(negedge clock);
      aluOp8 = 2'b10; funcCode8 = 6'b011000; opA8 = 8'h80; opB8 = 8'h80; start8 = 1'b1;
      @(negedge clock);
      start8 = 1'b0; funcCode8 = 6'b100000;
      nb = 0;
      while (busy8 && nb < 50) begin
         nb++;
         @(negedge clock);
      end
      chk("w8_busy_cycles", 64'(nb), 64'd9);
      chk("w8_done", {63'd0, done8}, 64'd1);
      chk("w8_hi", {56'd0, hi8}, 64'h40);
      chk("w8_lo", {56'd0, lo8}, 64'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
